ca_seed_controller: RTL and testbench

//  Control stage directly upstream of the CA line engine: latches the rule and seed-mode switches,

---
 rtl/ca_seed_controller.sv | 154 +++++++++++++++
 tb/tb_ca_seed_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ca_seed_controller.sv
// Seed/copy controller upstream of the CA line engine: writes row 0,
// gates the engine per frame and recycles the final row on KEY3.
module ca_seed_controller #(
  parameter int          H_PIXELS        = 640,
  parameter logic [10:0] ROW0_BASE       = 11'd0,
  parameter logic [10:0] FINAL_BASE      = 11'd1280,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [15:0] WHITE           = 16'hFF00,
  parameter logic [15:0] BLACK           = 16'h0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [7:0]  rule_sw_i,
  input  logic        seed_or_random_i,
  input  logic        next_key_n_i,
  input  logic        start_of_frame_i,
  input  logic        frame_done_i,
  input  logic [15:0] mem_read_data_i,
  output logic [10:0] mem_read_address_o,
  output logic [10:0] mem_write_address_o,
  output logic        mem_write_enable_o,
  output logic [15:0] mem_write_data_o,
  output logic [7:0]  rule_o,
  output logic        ca_enable_o,
  output logic        busy_o
);

  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(H_PIXELS - 1);
  localparam logic [CW-1:0] ENDC = CW'(H_PIXELS);
  localparam logic [CW-1:0] MID  = CW'(H_PIXELS / 2);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S_CAPTURE, S_SEED, S_WAIT_SOF, S_RUN, S_HOLD, S_COPY
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    rule_q, rule_d;
  logic          mode_q, mode_d;
  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_q, deb_d;
  logic          press_q, press_d;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_CAPTURE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      rule_q  <= '0;
      mode_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rule_q  <= rule_d;
      mode_q  <= mode_d;
      sync1_q <= next_key_n_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  // Press fires once on the step into saturation; a high sample re-arms.
  always_comb begin
    deb_d = deb_q;
    if (sync2_q) deb_d = '0;
    else if (deb_q != DMAX) deb_d = deb_q + DW'(1);
    press_d = !sync2_q && (deb_q == DMAX - DW'(1));
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    lfsr_d              = lfsr_q;
    rule_d              = rule_q;
    mode_d              = mode_q;
    mem_read_address_o  = '0;
    mem_write_address_o = '0;
    mem_write_enable_o  = 1'b0;
    mem_write_data_o    = '0;
    ca_enable_o         = 1'b0;
    busy_o              = 1'b0;
    unique case (state_q)
      S_CAPTURE: begin
        rule_d  = rule_sw_i;
        mode_d  = seed_or_random_i;
        cnt_d   = '0;
        state_d = S_SEED;
      end
      S_SEED: begin
        busy_o              = 1'b1;
        mem_write_enable_o  = 1'b1;
        mem_write_address_o = ROW0_BASE + 11'(cnt_q);
        if (mode_q) begin
          mem_write_data_o = (cnt_q == MID) ? BLACK : WHITE;
        end else begin
          mem_write_data_o = lfsr_q[0] ? BLACK : WHITE;
          lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_SOF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_SOF: begin
        if (start_of_frame_i) state_d = S_RUN;
      end
      S_RUN: begin
        ca_enable_o = 1'b1;
        if (frame_done_i) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (press_q) begin
          cnt_d   = '0;
          state_d = S_COPY;
        end
      end
      S_COPY: begin
        // Read leads write by one cycle to cover the RAM read latency.
        busy_o = 1'b1;
        if (cnt_q != ENDC) begin
          mem_read_address_o = FINAL_BASE + 11'(cnt_q);
        end
        if (cnt_q != '0) begin
          mem_write_enable_o  = 1'b1;
          mem_write_address_o = ROW0_BASE + 11'(cnt_q - CW'(1));
          mem_write_data_o    = mem_read_data_i;
        end
        if (cnt_q == ENDC) begin
          cnt_d   = '0;
          state_d = S_WAIT_SOF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_CAPTURE;
    endcase
  end

  assign rule_o = rule_q;

endmodule

// File: tb/tb_ca_seed_controller.sv
// Directed bench for ca_seed_controller: seeding, frame gating,
// debounced copy and mid-seed reset, against a line-RAM model.
module tb_ca_seed_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rule_sw;
  logic        sw17;
  logic        key_n;
  logic        sof;
  logic        fd;
  logic [15:0] rdata = '0;
  logic [10:0] raddr;
  logic [10:0] waddr;
  logic        we;
  logic [15:0] wdata;
  logic [7:0]  rule_o;
  logic        ca_en;
  logic        busy;

  int ntests = 0;
  int nfail  = 0;

  logic [15:0] ram [0:2047];
  logic [10:0] log_a [0:4095];
  logic [15:0] log_d [0:4095];
  int wr_cnt = 0;
  int bad_wr = 0;

  always #5 clk = ~clk;

  ca_seed_controller #(.DEBOUNCE_CYCLES(200)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .rule_sw_i(rule_sw), .seed_or_random_i(sw17),
    .next_key_n_i(key_n), .start_of_frame_i(sof),
    .frame_done_i(fd), .mem_read_data_i(rdata),
    .mem_read_address_o(raddr), .mem_write_address_o(waddr),
    .mem_write_enable_o(we), .mem_write_data_o(wdata),
    .rule_o(rule_o), .ca_enable_o(ca_en), .busy_o(busy)
  );

  function automatic logic [15:0] fin(input logic [10:0] a);
    return ({5'd0, a} * 16'd37) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Final-row region is a fixed pattern; row 0 is real storage.
  always @(posedge clk) begin
    rdata <= (raddr >= 11'd1280) ? fin(raddr) : ram[raddr];
    if (we) ram[waddr] <= wdata;
  end

  always @(negedge clk) begin
    if (we) begin
      if (wr_cnt < 4096) begin
        log_a[wr_cnt] = waddr;
        log_d[wr_cnt] = wdata;
      end
      wr_cnt++;
      if (!busy || ca_en) bad_wr++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int lim,
                           input string tag);
    int n = 0;
    while (busy !== lvl && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic chk_seed(input int base, input int ncell,
                          input logic mode, input string tag);
    logic [15:0] l = 16'hACE1;
    logic [15:0] e;
    int errs = 0;
    for (int k = 0; k < ncell; k++) begin
      if (mode) e = (k == 320) ? 16'h0000 : 16'hFF00;
      else e = l[0] ? 16'h0000 : 16'hFF00;
      l = lfsr_step(l);
      if (log_a[base+k] !== 11'(k) || log_d[base+k] !== e) errs++;
    end
    check(tag, errs, 0);
  endtask

  initial begin
    int base;
    int errs;
    rst_n   = 1'b0;
    rule_sw = 8'd30;
    sw17    = 1'b1;
    key_n   = 1'b1;
    sof     = 1'b0;
    fd      = 1'b0;
    tick(3);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_we", {31'd0, we}, 0);
    check("rst_ca_en", {31'd0, ca_en}, 0);
    check("rst_rule", {24'd0, rule_o}, 0);
    check("rst_waddr", {21'd0, waddr}, 0);

    // T1: centre-cell seed
    base  = wr_cnt;
    rst_n = 1'b1;
    wait_busy(1'b1, 10, "t1_busy_rise");
    rule_sw = 8'd77;
    wait_busy(1'b0, 700, "t1_busy_fall");
    check("t1_rule", {24'd0, rule_o}, 30);
    check("t1_count", wr_cnt - base, 640);
    chk_seed(base, 640, 1'b1, "t1_data");
    check("t1_ram320", {16'd0, ram[320]}, 32'h0000);
    check("t1_ram319", {16'd0, ram[319]}, 32'hFF00);

    // T3 / T5: frame gating, key in RUN ignored
    tick(5);
    check("t3_wait_en", {31'd0, ca_en}, 0);
    sof = 1'b1;
    check("t3_sof_cycle", {31'd0, ca_en}, 0);
    tick(1);
    sof = 1'b0;
    check("t3_run_en", {31'd0, ca_en}, 1);
    key_n = 1'b0;
    tick(300);
    key_n = 1'b1;
    tick(5);
    check("t5_run_en", {31'd0, ca_en}, 1);
    fd = 1'b1;
    check("t3_fd_cycle", {31'd0, ca_en}, 1);
    tick(1);
    fd = 1'b0;
    check("t3_hold_en", {31'd0, ca_en}, 0);
    sof = 1'b1;
    tick(1);
    sof = 1'b0;
    check("t3_sof_in_hold", {31'd0, ca_en}, 0);
    tick(300);
    check("t5_no_copy", wr_cnt - base, 640);
    check("t5_busy", {31'd0, busy}, 0);

    // T4: short press ignored, full press copies once
    key_n = 1'b0;
    tick(100);
    key_n = 1'b1;
    tick(300);
    check("t4_short", wr_cnt - base, 640);
    base  = wr_cnt;
    key_n = 1'b0;
    wait_busy(1'b1, 400, "t4_busy_rise");
    check("t4_first_raddr", {21'd0, raddr}, 1280);
    check("t4_first_we", {31'd0, we}, 0);
    wait_busy(1'b0, 1000, "t4_busy_fall");
    tick(400);
    key_n = 1'b1;
    check("t4_count", wr_cnt - base, 640);
    errs = 0;
    for (int k = 0; k < 640; k++) begin
      if (log_a[base+k] !== 11'(k)) errs++;
      if (log_d[base+k] !== fin(11'(1280 + k))) errs++;
    end
    check("t4_copy_data", errs, 0);
    check("t4_ram0", {16'd0, ram[0]}, {16'd0, fin(11'd1280)});
    check("t4_ram639", {16'd0, ram[639]}, {16'd0, fin(11'd1919)});
    check("t4_en_after", {31'd0, ca_en}, 0);

    // T2 / T6: LFSR seed, reset at cell 100, full reseed
    rst_n   = 1'b0;
    sw17    = 1'b0;
    rule_sw = 8'd110;
    tick(2);
    base  = wr_cnt;
    rst_n = 1'b1;
    errs  = 0;
    while (wr_cnt - base < 100 && errs < 200) begin
      tick(1);
      errs++;
    end
    check("t6_reach100", wr_cnt - base, 100);
    rst_n = 1'b0;
    #1;
    check("t6_we_now", {31'd0, we}, 0);
    check("t6_busy_now", {31'd0, busy}, 0);
    chk_seed(base, 100, 1'b0, "t2_partial");
    check("t2_k0", {16'd0, log_d[base]}, 32'h0000);
    check("t2_k1", {16'd0, log_d[base+1]}, 32'hFF00);
    rule_sw = 8'd90;
    tick(3);
    check("t6_held", wr_cnt - base, 100);
    base  = wr_cnt;
    rst_n = 1'b1;
    wait_busy(1'b1, 10, "t6_busy_rise");
    wait_busy(1'b0, 700, "t6_busy_fall");
    check("t6_rule", {24'd0, rule_o}, 90);
    check("t6_count", wr_cnt - base, 640);
    chk_seed(base, 640, 1'b0, "t6_lfsr_data");
    check("bad_writes", bad_wr, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
